rr_port_arbiter: RTL and testbench
==================================

Name: rr_port_arbiter

Overview:
- Four-requester round-robin arbiter that shares one single-ported resource (e.g. unified memory port: IF, MEM, debug, DMA) inside the pipelined CPU.
- Owns the grant state machine and drives the 2-bit select of an internal mux_4_1 that routes the winning requester's payload to the resource.
- Supports back-to-back grants with zero bubble and a watchdog that releases a hung transaction.

Parameters:
- N, 32, payload width per requester (address/control bundle).
- TIMEOUT, 16, max BUSY cycles without res_done before forced release; 0 disables the watchdog.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request per requester; held high until its ack.
- req_payload  input  4*N  requester i payload in bits [i*N +: N].
- res_done  input  1  resource completes current transaction this cycle.
- grant  output  4  one-hot registered grant; 0 when idle.
- ack  output  4  grant & {4{res_done}} while BUSY (combinational).
- sel  output  2  registered index of current/last winner; drives mux select.
- res_valid  output  1  high while BUSY.
- res_payload  output  N  req_payload slice selected by sel.
- timeout_err  output  1  one-cycle registered pulse on watchdog release.

Behaviour:
- Reset (synchronous): state=IDLE, grant=0, sel=2'b00, res_valid=0, timeout_err=0, watchdog count=0, last-winner pointer=3 (req[0] has top priority first).
- States: IDLE, BUSY.
- Priority: scan (last+1)%4, (last+2)%4, ... up to last; first asserted eligible req wins.
- IDLE: if |req, next edge goes to BUSY with grant=onehot(winner), sel=winner, last=winner, count=0; otherwise stay IDLE, grant=0. Latency from req to grant: 1 cycle.
- BUSY: grant, sel and payload held stable; count increments each cycle.
- BUSY with res_done=1: ack[winner]=1 this cycle. Re-arbitrate the same cycle with the current winner masked out. If another req is pending, next edge grants it, staying in BUSY with count=0. If none, go to IDLE.
- Requester must drop req the cycle after its ack. If it re-raises req, it is eligible again only from the following arbitration.
- Watchdog (TIMEOUT>0): if count==TIMEOUT-1 and res_done=0, next edge goes to IDLE with grant=0, timeout_err=1 for one cycle, no ack, and last=timed-out winner. No back-to-back grant on timeout.
- res_done while IDLE is ignored; no ack.
- req dropped while granted (protocol violation): grant held until res_done or timeout.
- Simultaneous res_done and count==TIMEOUT-1: res_done wins, normal completion, no error.
- rst mid-transaction: next edge forces the reset state. ack goes low because grant=0. A pending res_done is discarded.
- Width rule: count is $clog2(TIMEOUT+1) bits (min 1), saturating, never wraps.

Decomposition:
- Shared package: state encoding localparams (ST_IDLE=1'b0, ST_BUSY=1'b1), REQ_CNT=4.
- Sub-module rr_pick4: combinational; inputs req[3:0], mask[3:0], last[1:0]; outputs valid and idx[1:0].
- Payload routing uses an existing mux_4_1 #(.n(N)) instance with sel.

Test Plan:
- Single request: req=4'b0100 after reset → grant=4'b0100 and sel=2 next cycle. res_done at cycle 3 → ack=4'b0100 that cycle, grant=0 the cycle after.
- All four held, res_done every cycle → grants in order 0,1,2,3,0 with no idle cycle between them; res_payload matches each slice.
- Fairness: req=4'b1001 constant, winner last=0 → next winner 3, then 0, alternating.
- Watchdog: TIMEOUT=4, req=4'b0010, no res_done → timeout_err pulses exactly 4 BUSY cycles after grant. grant=0, no ack; re-grant to 1 only if still requested.
- Done on last cycle: res_done asserted at count==TIMEOUT-1 → ack, timeout_err stays 0.
- Reset mid-BUSY: rst=1 for one cycle during grant=4'b1000 → grant=0, sel=0, res_valid=0 next cycle. With req=4'b1001 after reset, req[0] wins first.

Source files
------------

// File: rtl/rr_port_arbiter_pkg.sv
// Shared types for the four-port round-robin resource arbiter.
package rr_port_arbiter_pkg;
    localparam int REQ_CNT = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    function automatic logic [REQ_CNT-1:0] onehot4(input logic [1:0] i);
        return REQ_CNT'(1) << i;
    endfunction
endpackage

// File: rtl/mux_4_1.sv
// Plain 4:1 multiplexer, n bits wide.
module mux_4_1 #(
    parameter int n = 32
) (
    input  logic [1:0]   sel,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic [n-1:0] c,
    input  logic [n-1:0] d,
    output logic [n-1:0] y
);
    always_comb begin
        unique case (sel)
            2'd0:    y = a;
            2'd1:    y = b;
            2'd2:    y = c;
            default: y = d;
        endcase
    end
endmodule

// File: rtl/rr_port_arbiter_pick4.sv
// Round-robin picker: first unmasked request scanning from last+1.
module rr_pick4
    import rr_port_arbiter_pkg::*;
(
    input  logic [REQ_CNT-1:0] req,
    input  logic [REQ_CNT-1:0] mask,
    input  logic [1:0]         last,
    output logic               valid,
    output logic [1:0]         idx
);
    logic [1:0] cand;

    // Scan farthest offset first so the nearest eligible one overwrites.
    always_comb begin
        valid = 1'b0;
        idx   = last;
        cand  = last;
        for (int k = REQ_CNT; k >= 1; k--) begin
            cand = last + 2'(k);
            if (req[cand] && !mask[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end
endmodule

// File: rtl/rr_port_arbiter.sv
// Round-robin arbiter sharing one single-ported resource among four
// requesters, with zero-bubble handover and a hung-transaction watchdog.
module rr_port_arbiter
    import rr_port_arbiter_pkg::*;
#(
    parameter int N       = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REQ_CNT-1:0]   req,
    input  logic [REQ_CNT*N-1:0] req_payload,
    input  logic                 res_done,
    output logic [REQ_CNT-1:0]   grant,
    output logic [REQ_CNT-1:0]   ack,
    output logic [1:0]           sel,
    output logic                 res_valid,
    output logic [N-1:0]         res_payload,
    output logic                 timeout_err
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST =
        CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_e             state, nxt_state;
    logic [REQ_CNT-1:0] nxt_grant;
    logic [1:0]         nxt_sel, last, nxt_last;
    logic [CW-1:0]      count, nxt_count;
    logic               nxt_terr;
    logic [REQ_CNT-1:0] pick_mask;
    logic               pick_valid;
    logic [1:0]         pick_idx;

    assign res_valid = (state == ST_BUSY);
    assign ack       = grant & {REQ_CNT{res_done && res_valid}};
    // The current owner sits out the re-arbitration that ends its turn.
    assign pick_mask = res_valid ? grant : '0;

    rr_pick4 u_pick (
        .req   (req),
        .mask  (pick_mask),
        .last  (last),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    mux_4_1 #(.n(N)) u_mux (
        .sel (sel),
        .a   (req_payload[0*N +: N]),
        .b   (req_payload[1*N +: N]),
        .c   (req_payload[2*N +: N]),
        .d   (req_payload[3*N +: N]),
        .y   (res_payload)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            grant       <= '0;
            sel         <= 2'd0;
            last        <= 2'd3;
            count       <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= nxt_state;
            grant       <= nxt_grant;
            sel         <= nxt_sel;
            last        <= nxt_last;
            count       <= nxt_count;
            timeout_err <= nxt_terr;
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_grant = grant;
        nxt_sel   = sel;
        nxt_last  = last;
        nxt_count = count;
        nxt_terr  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                nxt_grant = '0;
                if (pick_valid) begin
                    nxt_state = ST_BUSY;
                    nxt_grant = onehot4(pick_idx);
                    nxt_sel   = pick_idx;
                    nxt_last  = pick_idx;
                    nxt_count = '0;
                end
            end
            ST_BUSY: begin
                if (res_done) begin
                    if (pick_valid) begin
                        nxt_grant = onehot4(pick_idx);
                        nxt_sel   = pick_idx;
                        nxt_last  = pick_idx;
                        nxt_count = '0;
                    end else begin
                        nxt_state = ST_IDLE;
                        nxt_grant = '0;
                    end
                end else if (TIMEOUT > 0 && count == CNT_LAST) begin
                    nxt_state = ST_IDLE;
                    nxt_grant = '0;
                    nxt_terr  = 1'b1;
                end else if (count != '1) begin
                    nxt_count = count + CW'(1);
                end
            end
            default: nxt_state = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_rr_port_arbiter.sv
// Directed plus random stimulus against a cycle-level reference model.
module tb_rr_port_arbiter;
    localparam int N  = 32;
    localparam int TO = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [3:0]     req = '0;
    logic [4*N-1:0] req_payload = '0;
    logic           res_done = 1'b0;
    logic [3:0]     grant, ack;
    logic [1:0]     sel;
    logic           res_valid, timeout_err;
    logic [N-1:0]   res_payload;

    int compared = 0;
    int mismatched = 0;

    // Reference model: who owns the resource, for how long, who went last.
    bit m_busy;
    int m_owner, m_last, m_sel, m_age;
    bit m_terr;

    rr_port_arbiter #(.N(N), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_payload (req_payload),
        .res_done    (res_done),
        .grant       (grant),
        .ack         (ack),
        .sel         (sel),
        .res_valid   (res_valid),
        .res_payload (res_payload),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int next_winner(input logic [3:0] r, input int excl);
        for (int k = 1; k <= 4; k++) begin
            int i;
            i = (m_last + k) % 4;
            if (r[i] && i != excl) return i;
        end
        return -1;
    endfunction

    task automatic model_edge(input logic [3:0] r, input bit d, input bit rs);
        int w;
        m_terr = 0;
        if (rs) begin
            m_busy = 0; m_sel = 0; m_last = 3; m_age = 0;
        end else if (!m_busy) begin
            w = next_winner(r, -1);
            if (w >= 0) begin
                m_busy = 1; m_owner = w; m_sel = w; m_last = w; m_age = 0;
            end
        end else if (d) begin
            w = next_winner(r, m_owner);
            if (w >= 0) begin
                m_owner = w; m_sel = w; m_last = w; m_age = 0;
            end else begin
                m_busy = 0;
            end
        end else if (m_age == TO - 1) begin
            m_busy = 0; m_terr = 1;
        end else begin
            m_age++;
        end
    endtask

    task automatic step(input logic [3:0] r, input bit d, input bit rs = 0);
        logic [3:0] eg;
        @(negedge clk);
        req = r; res_done = d; rst = rs;
        req_payload = {$urandom, $urandom, $urandom, $urandom};
        #1;
        eg = m_busy ? 4'(1 << m_owner) : 4'b0;
        chk("grant", 32'(grant), 32'(eg));
        chk("sel", 32'(sel), 32'(m_sel));
        chk("res_valid", 32'(res_valid), 32'(m_busy));
        chk("timeout_err", 32'(timeout_err), 32'(m_terr));
        chk("ack", 32'(ack), 32'(d ? eg : 4'b0));
        chk("res_payload", res_payload, req_payload[m_sel*N +: N]);
        model_edge(r, d, rs);
    endtask

    initial begin
        m_busy = 0; m_sel = 0; m_last = 3; m_age = 0; m_terr = 0; m_owner = 0;
        step(4'b0000, 0, 1);
        step(4'b0000, 1, 1);
        chk("reset_grant", 32'(grant), 32'd0);
        chk("reset_sel", 32'(sel), 32'd0);

        // single request, done on third busy cycle
        step(4'b0100, 0);
        step(4'b0100, 0);
        chk("single_grant", 32'(grant), 32'b0100);
        chk("single_sel", 32'(sel), 32'd2);
        step(4'b0100, 0);
        step(4'b0100, 1);
        chk("single_ack", 32'(ack), 32'b0100);
        step(4'b0000, 0);
        chk("single_release", 32'(grant), 32'd0);

        // all four held, done every cycle
        step(4'b0000, 0, 1);
        step(4'b1111, 0);
        for (int i = 0; i < 6; i++) begin
            step(4'b1111, 1);
            chk("rr_order", 32'(sel), 32'(i % 4));
        end

        // fairness with two requesters
        step(4'b0000, 0, 1);
        step(4'b1001, 0);
        for (int i = 0; i < 5; i++) step(4'b1001, 1);

        // watchdog: no res_done
        step(4'b0000, 0, 1);
        for (int i = 0; i < 5; i++) step(4'b0010, 0);
        step(4'b0010, 0);
        chk("wd_pulse", 32'(timeout_err), 32'd1);
        chk("wd_grant", 32'(grant), 32'd0);
        step(4'b0010, 0);
        chk("wd_single_pulse", 32'(timeout_err), 32'd0);
        step(4'b0010, 0);
        chk("wd_regrant", 32'(grant), 32'b0010);

        // done on the last allowed cycle
        step(4'b0000, 0, 1);
        step(4'b0010, 0);
        for (int i = 0; i < 3; i++) step(4'b0010, 0);
        step(4'b0010, 1);
        chk("last_cycle_ack", 32'(ack), 32'b0010);
        step(4'b0000, 0);
        chk("last_cycle_noerr", 32'(timeout_err), 32'd0);

        // reset mid-transaction
        step(4'b0000, 0, 1);
        step(4'b1000, 0);
        step(4'b1000, 0);
        step(4'b1000, 1, 1);
        step(4'b1001, 0);
        chk("rst_mid_grant", 32'(grant), 32'd0);
        step(4'b1001, 0);
        chk("rst_mid_winner", 32'(grant), 32'b0001);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            step(4'($urandom), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 60) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end
endmodule
